// File: rtl/stereolbm_axis_cambm_hls_deadlock_ctrl_if.sv
// rtl/stereolbm_axis_cambm_hls_deadlock_ctrl_if.sv - deadlock report valid/ready channel
interface stereolbm_axis_cambm_hls_deadlock_ctrl_if #(
    parameter int ID_W = 2
);
    logic            report_valid;
    logic            report_ready;
    logic [ID_W-1:0] report_proc_id;
    logic [7:0]      report_cycles;

    modport master (
        output report_valid,
        output report_proc_id,
        output report_cycles,
        input  report_ready
    );

    modport slave (
        input  report_valid,
        input  report_proc_id,
        input  report_cycles,
        output report_ready
    );
endinterface

// File: rtl/stereolbm_axis_cambm_hls_deadlock_ctrl.sv
// rtl/stereolbm_axis_cambm_hls_deadlock_ctrl.sv - deadlock confirm/trace/report sequencer
module stereolbm_axis_cambm_hls_deadlock_ctrl #(
    parameter int PROC_NUM       = 4,
    parameter int CONFIRM_CYCLES = 16,
    parameter int TRACE_TIMEOUT  = 64,
    parameter int ID_W           = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PROC_NUM-1:0] dl_detect_vec,
    output logic                dl_detect_in,
    output logic [PROC_NUM-1:0] origin_vec,
    output logic                token_clear,
    stereolbm_axis_cambm_hls_deadlock_ctrl_if.master report,
    output logic                deadlock,
    input  logic                sw_clear,
    output logic [7:0]          false_alarm_cnt
);

    // One counter serves both the confirm window and the trace window.
    localparam int CNT_MAX = (CONFIRM_CYCLES > TRACE_TIMEOUT) ? CONFIRM_CYCLES : TRACE_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CONFIRM_LAST = CNT_W'(CONFIRM_CYCLES - 1);
    localparam logic [CNT_W-1:0] TRACE_LAST   = CNT_W'(TRACE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONFIRM,
        S_LAUNCH,
        S_TRACE,
        S_REPORT,
        S_LOCKED
    } state_t;

    state_t          state, state_nxt;
    logic [ID_W-1:0] sel, sel_nxt, lowest_id;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic            sel_hit;
    logic            latch_report;
    logic            count_false;
    logic [7:0]      cycles_calc;
    logic [ID_W-1:0] rpt_id_q;
    logic [7:0]      rpt_cycles_q;

    // Lowest-index candidate wins when several units flag at once.
    always_comb begin
        lowest_id = '0;
        for (int i = PROC_NUM - 1; i >= 0; i--) begin
            if (dl_detect_vec[i]) lowest_id = ID_W'(i);
        end
    end

    assign sel_hit     = dl_detect_vec[sel];
    assign cycles_calc = (int'(cnt) >= 254) ? 8'd255 : 8'(int'(cnt) + 1);

    // Next-state and counter control; sw_clear overrides every transition.
    always_comb begin
        state_nxt    = state;
        sel_nxt      = sel;
        cnt_nxt      = cnt;
        latch_report = 1'b0;
        count_false  = 1'b0;
        case (state)
            S_IDLE: begin
                if (|dl_detect_vec) begin
                    sel_nxt   = lowest_id;
                    cnt_nxt   = '0;
                    state_nxt = S_CONFIRM;
                end
            end
            S_CONFIRM: begin
                if (!sel_hit)                state_nxt = S_IDLE;
                else if (cnt == CONFIRM_LAST) state_nxt = S_LAUNCH;
                else                         cnt_nxt   = cnt + 1'b1;
            end
            S_LAUNCH: begin
                cnt_nxt   = '0;
                state_nxt = S_TRACE;
            end
            S_TRACE: begin
                if (sel_hit) begin
                    latch_report = 1'b1;
                    state_nxt    = S_REPORT;
                end else if (cnt == TRACE_LAST) begin
                    count_false = 1'b1;
                    state_nxt   = S_IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_REPORT: begin
                if (report.report_ready) state_nxt = S_LOCKED;
            end
            S_LOCKED: state_nxt = S_LOCKED;
            default:  state_nxt = S_IDLE;
        endcase
        if (sw_clear) begin
            state_nxt    = S_IDLE;
            latch_report = 1'b0;
            count_false  = 1'b0;
        end
    end

    // State, selected origin and window counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            sel   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            sel   <= sel_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Report payload is captured on token return and held afterwards.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rpt_id_q     <= '0;
            rpt_cycles_q <= '0;
        end else if (latch_report) begin
            rpt_id_q     <= sel;
            rpt_cycles_q <= cycles_calc;
        end
    end

    // Saturating count of traces that never saw their token come back.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                             false_alarm_cnt <= '0;
        else if (count_false && false_alarm_cnt != 8'hFF) false_alarm_cnt <= false_alarm_cnt + 1'b1;
    end

    assign dl_detect_in          = (state == S_LAUNCH) || (state == S_TRACE) ||
                                   (state == S_REPORT) || (state == S_LOCKED);
    assign origin_vec            = (state == S_LAUNCH) ? (PROC_NUM'(1) << sel) : '0;
    assign token_clear           = (state == S_TRACE) && sel_hit && !sw_clear;
    assign deadlock              = (state == S_LOCKED);
    assign report.report_valid   = (state == S_REPORT);
    assign report.report_proc_id = rpt_id_q;
    assign report.report_cycles  = rpt_cycles_q;

endmodule

// File: tb/tb_stereolbm_axis_cambm_hls_deadlock_ctrl.sv
// tb/tb_stereolbm_axis_cambm_hls_deadlock_ctrl.sv - directed bench for the deadlock sequencer
module tb_stereolbm_axis_cambm_hls_deadlock_ctrl;

    localparam int PROC_NUM = 4;
    localparam int ID_W     = 2;

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic [PROC_NUM-1:0] dl_detect_vec = '0;
    logic                sw_clear = 1'b0;
    logic                dl_detect_in;
    logic [PROC_NUM-1:0] origin_vec;
    logic                token_clear;
    logic                deadlock;
    logic [7:0]          false_alarm_cnt;

    int errors = 0;
    int checks = 0;

    stereolbm_axis_cambm_hls_deadlock_ctrl_if #(.ID_W(ID_W)) rpt ();

    stereolbm_axis_cambm_hls_deadlock_ctrl #(
        .PROC_NUM(PROC_NUM),
        .CONFIRM_CYCLES(16),
        .TRACE_TIMEOUT(64),
        .ID_W(ID_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .dl_detect_vec(dl_detect_vec),
        .dl_detect_in(dl_detect_in),
        .origin_vec(origin_vec),
        .token_clear(token_clear),
        .report(rpt),
        .deadlock(deadlock),
        .sw_clear(sw_clear),
        .false_alarm_cnt(false_alarm_cnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic confirm_window(input string tag);
        for (int k = 1; k <= 16; k++) begin
            step();
            check(tag, 32'(origin_vec), 0);
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rpt.report_ready = 1'b0;
        #3;
        check("rst_dl_in",    32'(dl_detect_in), 0);
        check("rst_origin",   32'(origin_vec), 0);
        check("rst_tclear",   32'(token_clear), 0);
        check("rst_valid",    32'(rpt.report_valid), 0);
        check("rst_id",       32'(rpt.report_proc_id), 0);
        check("rst_cycles",   32'(rpt.report_cycles), 0);
        check("rst_deadlock", 32'(deadlock), 0);
        check("rst_false",    32'(false_alarm_cnt), 0);
        step();
        reset = 1'b1;
        step();
        check("idle_dl_in", 32'(dl_detect_in), 0);

        // Persistent candidate on unit 2, token returns 5 cycles after origin
        dl_detect_vec = 4'b0100;
        confirm_window("t1_early_origin");
        check("t1_origin", 32'(origin_vec), 32'h4);
        check("t1_dl_in_launch", 32'(dl_detect_in), 1);
        dl_detect_vec = 4'b0000;
        for (int k = 1; k <= 4; k++) begin
            step();
            check("t1_origin_once", 32'(origin_vec), 0);
            check("t1_tclear_quiet", 32'(token_clear), 0);
            check("t1_dl_in_trace", 32'(dl_detect_in), 1);
        end
        step();
        dl_detect_vec = 4'b0100;
        #1;
        check("t1_tclear_pulse", 32'(token_clear), 1);
        step();
        dl_detect_vec = 4'b0000;
        check("t1_valid", 32'(rpt.report_valid), 1);
        check("t1_id", 32'(rpt.report_proc_id), 2);
        check("t1_cycles", 32'(rpt.report_cycles), 5);
        check("t1_no_deadlock_yet", 32'(deadlock), 0);
        rpt.report_ready = 1'b1;
        step();
        rpt.report_ready = 1'b0;
        check("t1_deadlock", 32'(deadlock), 1);
        check("t1_valid_drop", 32'(rpt.report_valid), 0);
        check("t1_dl_in_locked", 32'(dl_detect_in), 1);
        check("t1_cycles_held", 32'(rpt.report_cycles), 5);
        step();
        check("t1_still_locked", 32'(deadlock), 1);

        // sw_clear out of LOCKED
        sw_clear = 1'b1;
        step();
        sw_clear = 1'b0;
        check("clr_deadlock", 32'(deadlock), 0);
        check("clr_dl_in", 32'(dl_detect_in), 0);
        check("clr_false", 32'(false_alarm_cnt), 0);

        // Glitch: 10-cycle candidate never launches
        dl_detect_vec = 4'b0001;
        for (int k = 1; k <= 9; k++) begin
            step();
            check("glitch_origin", 32'(origin_vec), 0);
        end
        step();
        dl_detect_vec = 4'b0000;
        for (int k = 1; k <= 20; k++) begin
            step();
            check("glitch_origin_after", 32'(origin_vec), 0);
            check("glitch_dl_in", 32'(dl_detect_in), 0);
        end
        check("glitch_false", 32'(false_alarm_cnt), 0);

        // Timeout: token never returns
        dl_detect_vec = 4'b0001;
        confirm_window("to_early_origin");
        check("to_origin", 32'(origin_vec), 32'h1);
        dl_detect_vec = 4'b0000;
        for (int k = 1; k <= 64; k++) begin
            step();
            check("to_dl_in_trace", 32'(dl_detect_in), 1);
            check("to_false_pending", 32'(false_alarm_cnt), 0);
        end
        step();
        check("to_dl_in_drop", 32'(dl_detect_in), 0);
        check("to_false", 32'(false_alarm_cnt), 1);
        check("to_no_report", 32'(rpt.report_valid), 0);

        // Priority (1010 -> unit 1) and report backpressure
        dl_detect_vec = 4'b1010;
        confirm_window("pr_early_origin");
        check("pr_origin", 32'(origin_vec), 32'h2);
        dl_detect_vec = 4'b0000;
        step();
        dl_detect_vec = 4'b0010;
        #1;
        check("pr_tclear", 32'(token_clear), 1);
        step();
        dl_detect_vec = 4'b0000;
        for (int k = 1; k <= 20; k++) begin
            check("bp_valid", 32'(rpt.report_valid), 1);
            check("bp_id", 32'(rpt.report_proc_id), 1);
            check("bp_cycles", 32'(rpt.report_cycles), 1);
            step();
        end
        rpt.report_ready = 1'b1;
        step();
        rpt.report_ready = 1'b0;
        check("bp_deadlock", 32'(deadlock), 1);
        sw_clear = 1'b1;
        step();
        sw_clear = 1'b0;
        check("bp_clr_deadlock", 32'(deadlock), 0);
        check("bp_clr_dl_in", 32'(dl_detect_in), 0);
        check("bp_false_kept", 32'(false_alarm_cnt), 1);

        // Reset in the middle of a trace
        dl_detect_vec = 4'b0100;
        confirm_window("rs_early_origin");
        check("rs_origin", 32'(origin_vec), 32'h4);
        dl_detect_vec = 4'b0000;
        step();
        step();
        reset = 1'b0;
        dl_detect_vec = 4'b0100;
        #1;
        check("rs_tclear", 32'(token_clear), 0);
        check("rs_dl_in", 32'(dl_detect_in), 0);
        check("rs_origin_zero", 32'(origin_vec), 0);
        check("rs_false", 32'(false_alarm_cnt), 0);
        step();
        step();
        reset = 1'b1;
        confirm_window("rs_replay_early");
        check("rs_replay_origin", 32'(origin_vec), 32'h4);
        sw_clear = 1'b1;
        dl_detect_vec = 4'b0000;
        step();
        sw_clear = 1'b0;
        check("rs_end_dl_in", 32'(dl_detect_in), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
